// File: rtl/run_controller_if.sv
// Control/status bundle between the debug front end and the run controller.
interface run_controller_if #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
);
    logic             run_req;
    logic             step_req;
    logic             halt_req;
    logic             clear_count;
    logic             bp_enable;
    logic [PC_W-1:0]  bp_addr;
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] instr_limit;
    logic             cpu_en;
    logic [1:0]       state;
    logic [CNT_W-1:0] instr_count;
    logic             bp_hit;
    logic             limit_hit;

    modport master (
        output run_req, step_req, halt_req, clear_count, bp_enable, bp_addr, pc, instr_limit,
        input  cpu_en, state, instr_count, bp_hit, limit_hit
    );

    modport slave (
        input  run_req, step_req, halt_req, clear_count, bp_enable, bp_addr, pc, instr_limit,
        output cpu_en, state, instr_count, bp_hit, limit_hit
    );
endinterface

// File: rtl/run_controller.sv
// Debug run/step/halt controller: gates the datapath clock-enable, counts executed
// instructions and stops on halt, breakpoint or instruction limit.
module run_controller #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    run_controller_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        BRK  = 2'b11
    } state_t;

    state_t           r_state;
    logic             r_run_q, r_step_q, r_halt_q;
    logic             r_primed;
    logic             r_skip;
    logic             r_limit_hit;
    logic [CNT_W-1:0] r_count;

    logic w_run_e, w_step_e, w_halt_e;
    logic w_halt, w_run, w_step;
    logic w_bp_match, w_limit_reach, w_stop, w_cpu_en, w_leave_brk;

    // r_primed suppresses edges on the first clock after reset, so a request
    // held through release only loads its history register.
    assign w_run_e  = r_primed & bus.run_req  & ~r_run_q;
    assign w_step_e = r_primed & bus.step_req & ~r_step_q;
    assign w_halt_e = r_primed & bus.halt_req & ~r_halt_q;

    assign w_halt = w_halt_e;
    assign w_run  = w_run_e & ~w_halt_e;
    assign w_step = w_step_e & ~w_halt_e & ~w_run_e;

    assign w_bp_match    = bus.bp_enable & (bus.pc == bus.bp_addr) & ~r_skip;
    assign w_limit_reach = (bus.instr_limit != '0) & (r_count >= bus.instr_limit);
    assign w_stop        = w_halt | w_bp_match | w_limit_reach;

    // Qualified by reset so the enable drops in the same cycle reset asserts.
    assign w_cpu_en = reset & ((r_state == STEP) | ((r_state == RUN) & ~w_stop));

    assign w_leave_brk = (r_state == BRK) & ~w_halt & (w_run | w_step);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_run_q     <= 1'b0;
            r_step_q    <= 1'b0;
            r_halt_q    <= 1'b0;
            r_primed    <= 1'b0;
            r_skip      <= 1'b0;
            r_limit_hit <= 1'b0;
            r_count     <= '0;
        end else begin
            r_run_q  <= bus.run_req;
            r_step_q <= bus.step_req;
            r_halt_q <= bus.halt_req;
            r_primed <= 1'b1;

            if (bus.clear_count)
                r_count <= '0;
            else if (w_cpu_en && (r_count != '1))
                r_count <= r_count + 1'b1;

            // Skip lets the instruction sitting at bp_addr retire once after a resume.
            if (w_leave_brk)
                r_skip <= 1'b1;
            else if (w_cpu_en || ((r_state == RUN) && w_stop))
                r_skip <= 1'b0;

            if (bus.clear_count)
                r_limit_hit <= 1'b0;
            else if ((r_state == RUN) && !w_halt && !w_bp_match && w_limit_reach)
                r_limit_hit <= 1'b1;

            case (r_state)
                IDLE, BRK: begin
                    if (w_halt)      r_state <= IDLE;
                    else if (w_run)  r_state <= RUN;
                    else if (w_step) r_state <= STEP;
                end
                RUN: begin
                    if (w_halt)             r_state <= IDLE;
                    else if (w_bp_match)    r_state <= BRK;
                    else if (w_limit_reach) r_state <= IDLE;
                end
                STEP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cpu_en      = w_cpu_en;
    assign bus.state       = r_state;
    assign bus.instr_count = r_count;
    assign bus.bp_hit      = (r_state == BRK);
    assign bus.limit_hit   = r_limit_hit;
endmodule

// File: tb/tb_run_controller.sv
// Randomized and directed bench for run_controller with a queue-based scoreboard.
module tb_run_controller;
    localparam int S_IDLE = 0, S_RUN = 1, S_STEP = 2, S_BRK = 3;

    logic clk, rst_n, rst2_n;

    run_controller_if #(.PC_W(8), .CNT_W(16)) ifc ();
    run_controller_if #(.PC_W(8), .CNT_W(4))  ifc2 ();

    run_controller #(.PC_W(8), .CNT_W(16)) dut  (.clk(clk), .reset(rst_n),  .bus(ifc));
    run_controller #(.PC_W(8), .CNT_W(4))  dut2 (.clk(clk), .reset(rst2_n), .bus(ifc2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [1:0]  st;
        logic [15:0] cnt;
        logic        bp;
        logic        lh;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model of controller behaviour, advanced once per driven cycle.
    int          m_st;
    logic [15:0] m_cnt;
    bit          m_lh, m_skip, m_primed, m_pr, m_ps, m_ph;
    bit          g_rr, g_sr, g_hr;
    bit          g_bpen;
    logic [7:0]  g_bpa, g_pc;
    logic [15:0] g_lim;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("cpu_en",      ifc.cpu_en,      e.en);
            chk("state",       ifc.state,       e.st);
            chk("instr_count", ifc.instr_count, e.cnt);
            chk("bp_hit",      ifc.bp_hit,      e.bp);
            chk("limit_hit",   ifc.limit_hit,   e.lh);
        end
    end

    task automatic cyc(input bit rr, input bit sr, input bit hr, input bit cc);
        exp_t e;
        bit re, se, he, r, s, h, bp, lr, en;
        int ns;
        @(posedge clk);
        #1;
        ifc.run_req = rr; ifc.step_req = sr; ifc.halt_req = hr; ifc.clear_count = cc;
        ifc.bp_enable = g_bpen; ifc.bp_addr = g_bpa; ifc.pc = g_pc; ifc.instr_limit = g_lim;
        he = m_primed && hr && !m_ph;
        re = m_primed && rr && !m_pr;
        se = m_primed && sr && !m_ps;
        h = he; r = re && !he; s = se && !he && !re;
        bp = g_bpen && (g_pc == g_bpa) && !m_skip;
        lr = (g_lim != 0) && (m_cnt >= g_lim);
        en = 0; ns = m_st;
        if (m_st == S_STEP) begin
            en = 1; ns = S_IDLE;
        end else if (m_st == S_RUN) begin
            if (h)       ns = S_IDLE;
            else if (bp) ns = S_BRK;
            else if (lr) ns = S_IDLE;
            else         en = 1;
        end else begin
            if (h)       ns = S_IDLE;
            else if (r)  ns = S_RUN;
            else if (s)  ns = S_STEP;
        end
        e.en = en; e.st = 2'(m_st); e.cnt = m_cnt; e.bp = (m_st == S_BRK); e.lh = m_lh;
        sb.push_back(e);
        if (m_st == S_BRK && ns != S_BRK && ns != S_IDLE) m_skip = 1;
        else if (en || (m_st == S_RUN && ns != S_RUN))     m_skip = 0;
        if (m_st == S_RUN && !h && !bp && lr) m_lh = 1;
        if (cc) m_lh = 0;
        if (cc) m_cnt = 0;
        else if (en && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
        m_st = ns; m_pr = rr; m_ps = sr; m_ph = hr; m_primed = 1;
        g_rr = rr; g_sr = sr; g_hr = hr;
        if (en) g_pc = g_pc + 1;
    endtask

    // Asserts reset between edges, checks outputs go to zero at once, then releases.
    task automatic do_reset(input bit hold_run);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        ifc.run_req = hold_run; ifc.step_req = 1'b0; ifc.halt_req = 1'b0; ifc.clear_count = 1'b0;
        #1;
        chk("rst_cpu_en",    ifc.cpu_en,      0);
        chk("rst_state",     ifc.state,       0);
        chk("rst_count",     ifc.instr_count, 0);
        chk("rst_bp_hit",    ifc.bp_hit,      0);
        chk("rst_limit_hit", ifc.limit_hit,   0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        m_st = S_IDLE; m_cnt = 0; m_lh = 0; m_skip = 0;
        m_primed = 1; m_pr = hold_run; m_ps = 0; m_ph = 0;
        g_rr = hold_run; g_sr = 0; g_hr = 0;
    endtask

    initial begin
        bit rr, sr, hr, cc;
        rst_n = 1'b0; rst2_n = 1'b0;
        g_bpen = 0; g_bpa = 8'h00; g_pc = 8'h00; g_lim = 16'h0;
        ifc.bp_enable = 0; ifc.bp_addr = 0; ifc.pc = 0; ifc.instr_limit = 0;
        ifc2.run_req = 0; ifc2.step_req = 0; ifc2.halt_req = 0; ifc2.clear_count = 0;
        ifc2.bp_enable = 0; ifc2.bp_addr = 0; ifc2.pc = 0; ifc2.instr_limit = 0;
        do_reset(0);

        // single step
        cyc(0,0,0,0); cyc(0,1,0,0); cyc(0,1,0,0); cyc(0,0,0,0);
        chk("step_count", ifc.instr_count, 1);
        chk("step_state", ifc.state, 0);

        // run then halt
        cyc(1,0,0,0); repeat (5) cyc(1,0,0,0); cyc(1,0,1,0); cyc(0,0,0,0);
        chk("runhalt_count", ifc.instr_count, 6);
        chk("runhalt_state", ifc.state, 0);
        cyc(0,0,0,1); cyc(0,0,0,0);
        chk("clear_count", ifc.instr_count, 0);

        // breakpoint and resume
        g_bpen = 1; g_bpa = 8'h04; g_pc = 8'h00;
        cyc(1,0,0,0); repeat (5) cyc(1,0,0,0); cyc(0,0,0,0);
        chk("bp_state", ifc.state, 3);
        chk("bp_hit",   ifc.bp_hit, 1);
        chk("bp_count", ifc.instr_count, 4);
        cyc(1,0,0,0); cyc(1,0,0,0); cyc(1,0,0,0);
        chk("resume_state", ifc.state, 1);
        chk("resume_count", ifc.instr_count, 5);
        cyc(1,0,1,0); cyc(0,0,0,1); g_bpen = 0;

        // instruction limit
        g_lim = 16'd3;
        cyc(0,0,0,0); cyc(1,0,0,0); repeat (4) cyc(1,0,0,0); cyc(0,0,0,0);
        chk("lim_count", ifc.instr_count, 3);
        chk("lim_hit",   ifc.limit_hit, 1);
        chk("lim_state", ifc.state, 0);
        cyc(0,0,0,1); cyc(0,0,0,0);
        chk("lim_clr_count", ifc.instr_count, 0);
        chk("lim_clr_hit",   ifc.limit_hit, 0);
        g_lim = 0;

        // simultaneous run and halt edges
        cyc(1,0,1,0); cyc(0,0,0,0);
        chk("conflict_state", ifc.state, 0);
        chk("conflict_en",    ifc.cpu_en, 0);

        // request held through reset release
        do_reset(1);
        cyc(1,0,0,0); cyc(1,0,0,0);
        chk("held_state", ifc.state, 0);

        // reset during RUN
        cyc(0,0,0,0); cyc(1,0,0,0); repeat (3) cyc(1,0,0,0);
        do_reset(0);

        // randomized traffic
        rr = 0; sr = 0; hr = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 6) == 0)   rr = ~rr;
            if ($urandom_range(0, 9) == 0)   sr = ~sr;
            if ($urandom_range(0, 19) == 0)  hr = ~hr;
            cc = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 40) == 0)  g_bpen = ~g_bpen;
            if ($urandom_range(0, 30) == 0)  g_bpa = 8'($urandom_range(0, 31));
            if ($urandom_range(0, 25) == 0)  g_pc = 8'($urandom_range(0, 31));
            if ($urandom_range(0, 50) == 0)
                g_lim = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'(m_cnt + $urandom_range(1, 8));
            if ($urandom_range(0, 700) == 0) do_reset(rr);
            else cyc(rr, sr, hr, cc);
        end
        @(negedge clk); #1;
        chk("sb_drained", sb.size(), 0);

        // saturation on a narrow counter
        @(negedge clk); rst2_n = 1'b1;
        @(posedge clk); #1; ifc2.run_req = 1'b1;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
        chk("sat_count5", ifc2.instr_count, 5);
        repeat (15) @(posedge clk);
        #1;
        chk("sat_count20", ifc2.instr_count, 4'hF);
        chk("sat_state",   ifc2.state, 1);
        chk("sat_en",      ifc2.cpu_en, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
